// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer
// Turns the SWI peripheral's level cpureset request (foreign clock domain) into a
// clean Nios II resetrequest/resettaken handshake in the core clock domain.
// Each phase that waits on the CPU is bounded by a timeout, the request is held for
// a minimum time, and a quiet gap follows every release. Status outputs expose
// progress, timeouts and a running count of completed sequences.
module cpu_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int TAKEN_TIMEOUT = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int MIN_GAP       = 8
) (
    input  logic       clock_core_sig,
    input  logic       qsys_reset_n_sig,
    input  logic       swi_cpureset,
    input  logic       cpu_resettaken,
    output logic       cpu_resetrequest,
    output logic       busy,
    output logic       timeout_flag,
    output logic [7:0] reset_count
);

    localparam int TW = $clog2(TAKEN_TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(MIN_GAP + 1);

    localparam logic [TW-1:0] TMO_LAST = TW'(TAKEN_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   req_s;
    logic                   req_s_d_reg;
    logic                   rise_reg;

    state_t                 state_reg;
    logic                   request_reg;
    logic                   busy_reg;
    logic                   flag_reg;
    logic [7:0]             count_reg;
    logic [TW-1:0]          tmo_cnt_reg;
    logic [HW-1:0]          hold_cnt_reg;
    logic [GW-1:0]          gap_cnt_reg;

    assign req_s = sync_reg[SYNC_STAGES-1];

    // Metastability synchroniser for the foreign-domain request level.
    always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
        if (!qsys_reset_n_sig) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], swi_cpureset};
        end
    end

    // Rising-edge detect on the synchronised level; the pulse is registered so
    // the FSM only ever sees a one-cycle, glitch-free trigger.
    always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
        if (!qsys_reset_n_sig) begin
            req_s_d_reg <= 1'b0;
            rise_reg    <= 1'b0;
        end else begin
            req_s_d_reg <= req_s;
            rise_reg    <= req_s & ~req_s_d_reg;
        end
    end

    // Handshake sequencer with registered outputs and bounded waits on the CPU.
    always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
        if (!qsys_reset_n_sig) begin
            state_reg    <= IDLE;
            request_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            flag_reg     <= 1'b0;
            count_reg    <= 8'd0;
            tmo_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Only a fresh edge starts a sequence; edges seen while busy
                    // were consumed by their one-cycle pulse and are gone.
                    if (rise_reg) begin
                        state_reg   <= REQ;
                        request_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        flag_reg    <= 1'b0;
                        tmo_cnt_reg <= '0;
                    end
                end
                REQ: begin
                    // Taken is checked first so it wins over a same-cycle timeout.
                    if (cpu_resettaken) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= '0;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= '0;
                        flag_reg     <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg < HOLD_MAX) begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                    // A request level still asserted keeps the CPU in reset.
                    if ((hold_cnt_reg >= HOLD_MAX) && !req_s) begin
                        state_reg   <= RELEASE;
                        request_reg <= 1'b0;
                        count_reg   <= count_reg + 8'd1;
                        tmo_cnt_reg <= '0;
                    end
                end
                RELEASE: begin
                    if (!cpu_resettaken) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= '0;
                        flag_reg    <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    request_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_resetrequest = request_reg;
    assign busy             = busy_reg;
    assign timeout_flag     = flag_reg;
    assign reset_count      = count_reg;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Testbench for cpu_reset_sequencer.
// Each sequence is planned as input waveforms indexed by clock edge (edge 0 is the
// first edge that samples swi_cpureset high). The expected phase boundaries are
// derived from the timing rules by scanning those waveforms, and every output is
// compared on each falling edge against the resulting timeline.
module tb_cpu_reset_sequencer;

    localparam int T   = 1024;
    localparam int H   = 16;
    localparam int G   = 8;
    localparam int MAX = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       swi = 1'b0;
    logic       taken = 1'b0;
    logic       request;
    logic       busy;
    logic       flag;
    logic [7:0] count;

    int vectors = 0;
    int miscompares = 0;

    int   m_count = 0;
    bit   m_flag = 1'b0;
    bit   swi_a   [0:MAX-1];
    bit   taken_a [0:MAX-1];

    cpu_reset_sequencer #(
        .SYNC_STAGES  (2),
        .TAKEN_TIMEOUT(T),
        .HOLD_CYCLES  (H),
        .MIN_GAP      (G)
    ) dut (
        .clock_core_sig  (clk),
        .qsys_reset_n_sig(rst_n),
        .swi_cpureset    (swi),
        .cpu_resettaken  (taken),
        .cpu_resetrequest(request),
        .busy            (busy),
        .timeout_flag    (flag),
        .reset_count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    // Plans and runs one sequence.
    //  L  : edges swi_cpureset is high starting at edge 0
    //  d  : taken first sampled high at edge 3+d (0 = taken never asserted)
    //  k  : taken sampled low from edge (release + k)
    //  hp : extra swi pulse length starting 2 edges into HOLD (0 = none)
    //  gp : extra swi pulse length starting 1 edge into GAP (0 = none)
    task automatic run_seq(input string tag, input int L, input int d, input int k,
                           input int hp, input int gp);
        int hold_start, rel_start, gap_start, idle_at, last, base;
        bit tmo1, tmo2, prev_flag;
        bit e_req, e_busy, e_flag;
        logic [7:0] e_cnt;
        for (int i = 0; i < MAX; i++) begin
            swi_a[i]   = 1'b0;
            taken_a[i] = 1'b0;
        end
        for (int i = 0; i < L; i++) swi_a[i] = 1'b1;
        if (d > 0) for (int i = 3 + d; i < MAX; i++) taken_a[i] = 1'b1;
        // Request goes out after edge 3; first taken within T edges ends REQ.
        hold_start = 3 + T;
        tmo1 = 1'b1;
        for (int i = 1; i <= T; i++) begin
            if (taken_a[3 + i]) begin
                hold_start = 3 + i;
                tmo1 = 1'b0;
                break;
            end
        end
        for (int i = 0; i < hp; i++) swi_a[hold_start + 2 + i] = 1'b1;
        // HOLD needs H full counts, then a low synchronised request (two edges of latency).
        rel_start = hold_start + H + 1;
        while (swi_a[rel_start - 2]) rel_start++;
        if (d > 0) for (int i = rel_start + k; i < MAX; i++) taken_a[i] = 1'b0;
        gap_start = rel_start + T;
        tmo2 = 1'b1;
        for (int i = 1; i <= T; i++) begin
            if (!taken_a[rel_start + i]) begin
                gap_start = rel_start + i;
                tmo2 = 1'b0;
                break;
            end
        end
        idle_at = gap_start + G;
        for (int i = 0; i < gp; i++) swi_a[gap_start + 1 + i] = 1'b1;
        last = ((idle_at > gap_start + gp) ? idle_at : gap_start + gp) + 6;
        base = m_count;
        prev_flag = m_flag;

        // Quiet lead-in: the design must sit idle with unchanged status.
        for (int i = 0; i < 4; i++) begin
            swi = 1'b0;
            taken = 1'b0;
            @(negedge clk);
            vectors++;
            if ({request, busy, flag, count} !== {1'b0, 1'b0, prev_flag, 8'(base)}) begin
                miscompares++;
                $display("FAIL %s idle-lead %0d: got req=%b busy=%b flag=%b count=%0d, want req=0 busy=0 flag=%b count=%0d",
                         tag, i, request, busy, flag, count, prev_flag, 8'(base));
            end
        end

        for (int j = 0; j <= last; j++) begin
            swi = swi_a[j];
            taken = taken_a[j];
            @(negedge clk);
            e_req  = (j >= 3) && (j < rel_start);
            e_busy = (j >= 3) && (j < idle_at);
            e_cnt  = 8'(base + ((j >= rel_start) ? 1 : 0));
            if (j < 3) e_flag = prev_flag;
            else if (j < hold_start) e_flag = 1'b0;
            else if (j < gap_start) e_flag = tmo1;
            else e_flag = tmo1 | tmo2;
            vectors++;
            if ({request, busy, flag, count} !== {e_req, e_busy, e_flag, e_cnt}) begin
                miscompares++;
                $display("FAIL %s edge %0d: got req=%b busy=%b flag=%b count=%0d, want req=%b busy=%b flag=%b count=%0d",
                         tag, j, request, busy, flag, count, e_req, e_busy, e_flag, e_cnt);
            end
        end
        swi = 1'b0;
        taken = 1'b0;
        m_count = (base + 1) % 256;
        m_flag = tmo1 | tmo2;
        $display("seq %s: L=%0d d=%0d k=%0d hp=%0d gp=%0d hold@%0d rel@%0d gap@%0d idle@%0d flag=%b count=%0d",
                 tag, L, d, k, hp, gp, hold_start, rel_start, gap_start, idle_at, m_flag, m_count);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        swi = 1'b0;
        taken = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_count = 0;
        m_flag = 1'b0;
    endtask

    task automatic test_reset();
        swi = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({request, busy, flag, count} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset-async: got %b, want all zero", {request, busy, flag, count});
        end
        // A request level present during reset must not leak through.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({request, busy, flag, count} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset-held %0d: got %b, want all zero", i, {request, busy, flag, count});
            end
        end
        swi = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if ({request, busy, flag, count} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset-after %0d: got %b, want all zero", i, {request, busy, flag, count});
            end
        end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_basic();
        run_seq("basic", 40, 5, 3, 0, 0);
    endtask

    task automatic test_taken_timeout();
        run_seq("taken_timeout", 10, 0, 0, 0, 0);
        // Flag must still read 1 in the idle lead-in and clear on the next request.
        run_seq("flag_clear", 4, 2, 2, 0, 0);
    endtask

    task automatic test_release_timeout();
        run_seq("release_timeout", 5, 2, T + 20, 0, 0);
    endtask

    task automatic test_long_level();
        run_seq("long_level", 500, 3, 2, 0, 0);
    endtask

    task automatic test_ignored_edges();
        run_seq("ignored_edges", 5, 2, 2, 3, 30);
        run_seq("after_ignored", 7, 4, 1, 0, 0);
    endtask

    task automatic test_async_reset();
        // Drive into HOLD of a timed-out sequence so flag and count are both nonzero.
        repeat (4) @(negedge clk);
        for (int j = 0; j <= 3 + T + 5; j++) begin
            swi = (j < 6);
            taken = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if ({request, busy, flag} !== 3'b111) begin
            miscompares++;
            $display("FAIL in-hold: got req/busy/flag=%b, want 111", {request, busy, flag});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({request, busy, flag, count} !== 11'd0) begin
            miscompares++;
            $display("FAIL async-abort: got %b, want all zero", {request, busy, flag, count});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_count = 0;
        m_flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({request, busy, flag, count} !== 11'd0) begin
                miscompares++;
                $display("FAIL post-abort-idle %0d: got %b, want all zero", i, {request, busy, flag, count});
            end
        end
        $display("async_reset: sequence aborted in HOLD, idle afterwards");
        run_seq("post_abort", 6, 3, 2, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_seq("random", int'($urandom_range(1, 60)), int'($urandom_range(1, 30)),
                    int'($urandom_range(1, 10)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 20)));
        end
    endtask

    task automatic test_back_to_back_wrap();
        apply_reset();
        for (int n = 0; n < 257; n++) begin
            run_seq("wrap", int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 3)), 0, 0);
        end
        vectors++;
        if (count !== 8'd1) begin
            miscompares++;
            $display("FAIL wrap-count: got %0d, want 1", count);
        end
        $display("wrap: 257 sequences, count=%0d", count);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_taken_timeout();
        test_release_timeout();
        test_long_level();
        test_ignored_edges();
        test_random();
        test_async_reset();
        test_back_to_back_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
